if_fetch_unit: RTL and testbench



---
 rtl/if_fetch_unit_if.sv | 27 ++
 rtl/if_fetch_unit.sv | 114 +++++++++++
 tb/tb_if_fetch_unit.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// IF stage bundle: IMem request/response channel, redirect/stall controls and IF/ID outputs.
// master = fetch unit side, slave = environment (IMem + ID stage) side.
interface if_fetch_unit_if;
    logic        ImemReqValidOut;
    logic [31:0] ImemReqAddrOut;
    logic        ImemReqReadyIn;
    logic        ImemRespValidIn;
    logic [31:0] ImemRespDataIn;
    logic        RedirectIn;
    logic [31:0] RedirectAddrIn;
    logic        StallIn;
    logic [31:0] InsOut;
    logic [31:0] AddrOut;
    logic        ValidOut;

    modport master (
        output ImemReqValidOut, ImemReqAddrOut, InsOut, AddrOut, ValidOut,
        input  ImemReqReadyIn, ImemRespValidIn, ImemRespDataIn,
               RedirectIn, RedirectAddrIn, StallIn
    );

    modport slave (
        input  ImemReqValidOut, ImemReqAddrOut, InsOut, AddrOut, ValidOut,
        output ImemReqReadyIn, ImemRespValidIn, ImemRespDataIn,
               RedirectIn, RedirectAddrIn, StallIn
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC, IMem requests, in-order responses into a 2-entry buffer feeding IF/ID.
// Latency: request accepted N, response N+k -> ValidOut at N+k+1; StallIn holds output, fetch stops at 2 credits.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic          clkIn,
    input  logic          resetIn,
    if_fetch_unit_if.master fu
);

    logic [31:0] pc_q, pc_d;
    logic [1:0]  inflight_q, inflight_d;
    logic [1:0]  drop_q, drop_d;
    logic [31:0] aq_q [2];
    logic [31:0] aq_d [2];
    logic        aq_wr_q, aq_wr_d;
    logic        aq_rd_q, aq_rd_d;
    logic [31:0] buf_ins_q  [2];
    logic [31:0] buf_ins_d  [2];
    logic [31:0] buf_addr_q [2];
    logic [31:0] buf_addr_d [2];
    logic        hd_q, hd_d;
    logic [1:0]  count_q, count_d;

    logic        resp_fire, pop, keep, req_vld, req_fire, wr_idx;
    logic [2:0]  occ, cap;

    always_comb begin
        resp_fire = fu.ImemRespValidIn && (inflight_q != 2'd0);
        pop       = (count_q != 2'd0) && !fu.StallIn;
        keep      = resp_fire && (drop_q == 2'd0);
        occ       = {1'b0, inflight_q} + {1'b0, count_q};
        // The entry leaving the buffer this cycle frees its credit now, so a
        // zero-wait IMem can sustain one instruction per cycle.
        cap       = 3'(BUF_DEPTH) + {2'b00, pop};
        req_vld   = resetIn && !fu.RedirectIn && (occ < cap);
        req_fire  = req_vld && fu.ImemReqReadyIn;
        wr_idx    = hd_q ^ count_q[0];

        pc_d       = pc_q;
        inflight_d = inflight_q + {1'b0, req_fire} - {1'b0, resp_fire};
        drop_d     = drop_q;
        aq_d       = aq_q;
        aq_wr_d    = aq_wr_q;
        aq_rd_d    = aq_rd_q;
        buf_ins_d  = buf_ins_q;
        buf_addr_d = buf_addr_q;
        hd_d       = hd_q;
        count_d    = count_q + {1'b0, keep} - {1'b0, pop};

        if (req_fire) begin
            pc_d           = pc_q + 32'd4;
            aq_d[aq_wr_q]  = pc_q;
            aq_wr_d        = ~aq_wr_q;
        end
        if (resp_fire) begin
            aq_rd_d = ~aq_rd_q;
            if (drop_q != 2'd0) begin
                drop_d = drop_q - 2'd1;
            end
        end
        if (keep) begin
            buf_ins_d[wr_idx]  = fu.ImemRespDataIn;
            buf_addr_d[wr_idx] = aq_q[aq_rd_q];
        end
        if (pop) begin
            hd_d = ~hd_q;
        end

        // Everything still outstanding after this cycle belongs to the old path.
        if (fu.RedirectIn) begin
            pc_d    = fu.RedirectAddrIn & 32'hFFFF_FFFC;
            count_d = 2'd0;
            hd_d    = 1'b0;
            drop_d  = inflight_q - {1'b0, resp_fire};
        end
    end

    always_ff @(posedge clkIn) begin
        if (!resetIn) begin
            pc_q       <= RESET_PC & 32'hFFFF_FFFC;
            inflight_q <= 2'd0;
            drop_q     <= 2'd0;
            aq_wr_q    <= 1'b0;
            aq_rd_q    <= 1'b0;
            hd_q       <= 1'b0;
            count_q    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                aq_q[i]       <= 32'd0;
                buf_ins_q[i]  <= 32'd0;
                buf_addr_q[i] <= 32'd0;
            end
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            aq_wr_q    <= aq_wr_d;
            aq_rd_q    <= aq_rd_d;
            hd_q       <= hd_d;
            count_q    <= count_d;
            aq_q       <= aq_d;
            buf_ins_q  <= buf_ins_d;
            buf_addr_q <= buf_addr_d;
        end
    end

    assign fu.ImemReqValidOut = req_vld;
    assign fu.ImemReqAddrOut  = pc_q;
    assign fu.ValidOut        = (count_q != 2'd0);
    assign fu.InsOut          = (count_q != 2'd0) ? buf_ins_q[hd_q]  : 32'd0;
    assign fu.AddrOut         = (count_q != 2'd0) ? buf_addr_q[hd_q] : 32'd0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: an IMem model with programmable latency/ready and a
// scoreboard of expected {addr, ins} popped by an independent output monitor.
module tb_if_fetch_unit;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] ins;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    logic clk = 1'b0;
    logic resetIn;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   lat = 1;
    logic rdy_en = 1'b1;
    logic force_stall = 1'b0;

    exp_t  exp_q[$];
    pend_t pend_q[$];
    int    pop_cyc_q[$];

    if_fetch_unit_if fif();

    if_fetch_unit #(.RESET_PC(32'h0000_0100), .BUF_DEPTH(2)) dut (
        .clkIn   (clk),
        .resetIn (resetIn),
        .fu      (fif)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    function automatic logic [31:0] ins_of(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_addr(input logic [31:0] a);
        exp_t e;
        e.addr = a;
        e.ins  = ins_of(a);
        exp_q.push_back(e);
    endtask

    // One cycle of stimulus: the ID side only accepts when the scoreboard expects something.
    task automatic step();
        @(negedge clk);
        fif.StallIn = force_stall || (exp_q.size() == 0);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // IMem model: in-order responses lat cycles after acceptance.
    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    initial begin
        fif.ImemReqReadyIn  = 1'b1;
        fif.ImemRespValidIn = 1'b0;
        fif.ImemRespDataIn  = 32'd0;
        forever begin
            @(negedge clk);
            #1;
            fif.ImemReqReadyIn = rdy_en;
            if (resetIn && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                fif.ImemRespValidIn = 1'b1;
                fif.ImemRespDataIn  = ins_of(pend_q[0].addr);
                void'(pend_q.pop_front());
            end else begin
                fif.ImemRespValidIn = 1'b0;
                fif.ImemRespDataIn  = 32'd0;
            end
            #1;
            if (!resetIn) begin
                pend_q.delete();
                prev_hold = 1'b0;
            end else begin
                if (prev_hold && fif.ImemReqValidOut)
                    chk("req_addr_stable", fif.ImemReqAddrOut, prev_addr);
                prev_hold = fif.ImemReqValidOut && !fif.ImemReqReadyIn;
                prev_addr = fif.ImemReqAddrOut;
                if (fif.ImemReqValidOut && fif.ImemReqReadyIn) begin
                    pend_t p;
                    p.addr = fif.ImemReqAddrOut;
                    p.due  = cyc + lat;
                    pend_q.push_back(p);
                    chk("outstanding_le2", 32'(pend_q.size() <= 2), 32'd1);
                end
            end
        end
    end

    // Output monitor: every accepted instruction must match the scoreboard head.
    initial forever begin
        @(negedge clk);
        #4;
        if (resetIn && !fif.RedirectIn && fif.ValidOut && !fif.StallIn) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", fif.AddrOut, 32'hxxxx_xxxx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_addr", fif.AddrOut, e.addr);
                chk("out_ins", fif.InsOut, e.ins);
                pop_cyc_q.push_back(cyc);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetIn            = 1'b0;
        fif.RedirectIn     = 1'b0;
        fif.RedirectAddrIn = 32'd0;
        fif.StallIn        = 1'b1;

        // Reset state
        repeat (3) step();
        #3;
        chk("rst_valid", 32'(fif.ValidOut), 32'd0);
        chk("rst_ins", fif.InsOut, 32'd0);
        chk("rst_addr", fif.AddrOut, 32'd0);
        chk("rst_reqvalid", 32'(fif.ImemReqValidOut), 32'd0);

        // Back-to-back fetch from RESET_PC with a zero-wait IMem
        expect_addr(32'h100); expect_addr(32'h104); expect_addr(32'h108);
        pop_cyc_q.delete();
        step();
        resetIn = 1'b1;
        drain(20);
        if (pop_cyc_q.size() >= 3) begin
            chk("b2b_gap1", 32'(pop_cyc_q[1] - pop_cyc_q[0]), 32'd1);
            chk("b2b_gap2", 32'(pop_cyc_q[2] - pop_cyc_q[1]), 32'd1);
        end else begin
            chk("b2b_count", 32'(pop_cyc_q.size()), 32'd3);
        end

        // Stall holds the output; fetch stops once two credits are used
        force_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            #3;
            chk("stall_valid", 32'(fif.ValidOut), 32'd1);
            chk("stall_addr", fif.AddrOut, 32'h10C);
        end
        chk("stall_reqvalid", 32'(fif.ImemReqValidOut), 32'd0);
        force_stall = 1'b0;
        expect_addr(32'h10C); expect_addr(32'h110); expect_addr(32'h114);
        drain(20);

        // Reset mid-stream with the buffer full
        repeat (3) step();
        #3;
        chk("full_head", fif.AddrOut, 32'h118);
        step();
        resetIn = 1'b0;
        lat = 3;
        step();
        #3;
        chk("midrst_valid", 32'(fif.ValidOut), 32'd0);
        chk("midrst_ins", fif.InsOut, 32'd0);
        chk("midrst_addr", fif.AddrOut, 32'd0);
        chk("midrst_reqvalid", 32'(fif.ImemReqValidOut), 32'd0);
        step();
        resetIn = 1'b1;
        #3;
        chk("rel_reqvalid", 32'(fif.ImemReqValidOut), 32'd1);
        chk("rel_reqaddr", fif.ImemReqAddrOut, 32'h100);

        // Redirect with two requests in flight: both responses are dropped
        step();
        step();
        fif.RedirectIn     = 1'b1;
        fif.RedirectAddrIn = 32'h2002;
        #3;
        chk("redir_reqvalid", 32'(fif.ImemReqValidOut), 32'd0);
        chk("redir_inflight", 32'(pend_q.size()), 32'd2);
        step();
        fif.RedirectIn = 1'b0;
        expect_addr(32'h2000); expect_addr(32'h2004); expect_addr(32'h2008);
        drain(40);

        // Request held by IMem backpressure, 3-cycle response latency
        expect_addr(32'h200C); expect_addr(32'h2010);
        expect_addr(32'h2014); expect_addr(32'h2018);
        rdy_en = 1'b0;
        repeat (3) step();
        rdy_en = 1'b1;
        drain(40);

        // PC wrap at the top of the address space
        lat = 1;
        step();
        fif.RedirectIn     = 1'b1;
        fif.RedirectAddrIn = 32'hFFFF_FFFC;
        step();
        fif.RedirectIn = 1'b0;
        expect_addr(32'hFFFF_FFFC); expect_addr(32'h0000_0000); expect_addr(32'h0000_0004);
        drain(30);

        // Back-to-back redirects: the later target wins
        lat = 2;
        step();
        fif.RedirectIn     = 1'b1;
        fif.RedirectAddrIn = 32'h3000;
        step();
        fif.RedirectAddrIn = 32'h4001;
        step();
        fif.RedirectIn = 1'b0;
        expect_addr(32'h4000); expect_addr(32'h4004);
        drain(30);

        repeat (4) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
